l2_arbiter: RTL and testbench
=============================

// Module: l2_arbiter
// PURPOSE
//   Shares the single L2 cache port between the L1 I-cache (line reads only) and the L1 D-cache (line reads/writes).
//   Sits between both L1 miss ports and the L2 cache's L1-side interface.
//   Grants one whole-line transaction at a time; D-cache has priority, with a starvation bound for the I-cache.
//   Request fields are registered at grant, so L2 inputs are stable for the whole transaction.
// PARAMETERS
//   LINE_WIDTH    256  cache line width in bits (matches L2 mem_wdata_l1/mem_rdata_l1)
//   ADDR_WIDTH    32   byte address width
//   STARVE_LIMIT  4    max consecutive D grants while I is pending before I is forced; >=1
// PORTS
//   clk           in   1           clock, rising edge
//   rst           in   1           asynchronous active-high reset
//   i_read        in   1           I-cache line read request, held until i_resp
//   i_address     in   ADDR_WIDTH  I-cache line address
//   i_resp        out  1           1-cycle pulse: i_rdata valid, I transaction done
//   i_rdata       out  LINE_WIDTH  line returned to I-cache
//   d_read        in   1           D-cache line read request, held until d_resp
//   d_write       in   1           D-cache line write request, held until d_resp
//   d_address     in   ADDR_WIDTH  D-cache line address
//   d_wdata       in   LINE_WIDTH  D-cache writeback line
//   d_resp        out  1           1-cycle pulse: D transaction done, d_rdata valid on reads
//   d_rdata       out  LINE_WIDTH  line returned to D-cache
//   l2_read       out  1           to L2 mem_read
//   l2_write      out  1           to L2 mem_write
//   l2_address    out  ADDR_WIDTH  to L2 mem_address
//   l2_wdata      out  LINE_WIDTH  to L2 mem_wdata_l1
//   l2_resp       in   1           from L2 mem_resp
//   l2_rdata      in   LINE_WIDTH  from L2 mem_rdata_l1
// BEHAVIOUR
//   Reset: state IDLE; starve_cnt=0; l2_read/l2_write/i_resp/d_resp=0; l2_address/l2_wdata registers=0.
//   FSM states: IDLE, SERVE_I, SERVE_D.
//   IDLE:
//     - Evaluates i_req=i_read and d_req=d_read|d_write.
//     - d_req && (!i_req || starve_cnt<STARVE_LIMIT) -> SERVE_D.
//     - Otherwise, i_req -> SERVE_I. Neither -> stay IDLE.
//     - On the grant edge: latch address and (D only) d_wdata and the op into l2_* registers.
//   D op select: d_write=1 -> l2_write; else l2_read. d_read&d_write together is illegal (assertion fires); write wins.
//   SERVE_x:
//     - l2_read/l2_write held from the registered op. l2_address/l2_wdata held constant.
//     - On l2_resp=1: x_resp=1 combinationally in the same cycle; x_rdata=l2_rdata; l2_* deasserted next edge; -> IDLE.
//   Routing and response pulses:
//     - i_rdata/d_rdata are driven from l2_rdata (both outputs may share the wire).
//     - Only the granted side sees a resp pulse; the other side's resp stays 0.
//   Latency:
//     - Request seen in IDLE at cycle N -> l2_read/l2_write high from cycle N+1.
//     - x_resp coincides with l2_resp.
//     - IDLE occupies at least 1 cycle between transactions, so a requester that drops its request
//       the cycle after resp is never re-granted.
//   starve_cnt (width clog2(STARVE_LIMIT+1)), updated on the grant edge only:
//     - D grant with i_req=1: saturating +1.
//     - I grant, or D grant with i_req=0: reset to 0.
//     - Unchanged in SERVE states.
//   Request dropped mid-transaction: the L2 transaction still completes, then returns to IDLE.
//     The resp pulse is still emitted; the L1 ignores it.
//   l2_resp while in IDLE: ignored; no resp pulse is generated.
//   rst mid-transaction: immediate return to reset values, in-flight op abandoned (L2 shares rst).
// TESTING
//   1. I only: i_read=1, addr 0x0000_1040; L2 answers after 5 cycles with data D0.
//      -> l2_read=1 at N+1, l2_address=0x1040, i_resp pulses with i_rdata=D0, d_resp=0.
//   2. D write: d_write=1, addr 0x0000_2000, wdata W.
//      -> l2_write=1, l2_wdata=W for the whole transaction; d_resp one pulse; then IDLE for 1 cycle.
//   3. Simultaneous i_read and d_read every time (STARVE_LIMIT=2).
//      -> grant order D, D, I, D, D, I; starve_cnt goes 1, 2, 0.
//   4. d_address changed while in SERVE_D.
//      -> l2_address keeps the granted value until l2_resp.
//   5. rst asserted mid-SERVE_I.
//      -> l2_read=0 and state IDLE asynchronously, before the next edge; no i_resp.
//   6. i_read dropped before l2_resp.
//      -> l2_read stays high until l2_resp; the arbiter then returns to IDLE without hanging.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the L1 I-cache and L1 D-cache.
// One whole-line transaction at a time; D first, I forced after a starvation bound.
module l2_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic                  l2_resp,
    input  logic [LINE_WIDTH-1:0] l2_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic                  l2_read_q, l2_read_d;
    logic                  l2_write_q, l2_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic d_win;
    logic [CW-1:0] starve_inc;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // D wins unless I is waiting and D has already won LIMIT times in a row
    assign d_win = d_req && (!i_req || (starve_q < LIMIT));

    assign starve_inc = (starve_q == LIMIT) ? LIMIT : starve_q + ONE;

    // Grant, hold and release of the L2 port; resp pulses follow l2_resp
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_win) begin
                    state_d    = SERVE_D;
                    l2_write_d = d_write;
                    l2_read_d  = !d_write;
                    addr_d     = d_address;
                    wdata_d    = d_wdata;
                    starve_d   = i_req ? starve_inc : '0;
                end else if (i_req) begin
                    state_d    = SERVE_I;
                    l2_read_d  = 1'b1;
                    l2_write_d = 1'b0;
                    addr_d     = i_address;
                    starve_d   = '0;
                end
            end
            SERVE_I: begin
                i_resp = l2_resp;
                if (l2_resp) begin
                    state_d    = IDLE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                end
            end
            SERVE_D: begin
                d_resp = l2_resp;
                if (l2_resp) begin
                    state_d    = IDLE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end
        endcase
    end

    // State and latched request registers; reset abandons any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign l2_read    = l2_read_q;
    assign l2_write   = l2_write_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    // Both L1s see the raw L2 line; only the granted side gets a resp pulse
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // The D-cache must never ask for a read and a write at once
    a_d_op_onehot : assert property (
        @(posedge clk) disable iff (rst) !(d_read && d_write)
    );

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter.
module tb_l2_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
    localparam int SL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata;
    logic          l2_resp;
    logic [LW-1:0] l2_rdata;

    always #5 clk = ~clk;

    l2_arbiter #(
        .LINE_WIDTH  (LW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_address (i_address),
        .i_resp    (i_resp),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_address (d_address),
        .d_wdata   (d_wdata),
        .d_resp    (d_resp),
        .d_rdata   (d_rdata),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_address(l2_address),
        .l2_wdata  (l2_wdata),
        .l2_resp   (l2_resp),
        .l2_rdata  (l2_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the L2 port and what was captured at grant
    typedef enum {NONE, OWN_I, OWN_D} owner_t;
    owner_t        own;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            dstreak;
    int            lat;
    int            next_lat;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        own     = NONE;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        dstreak = 0;
        lat     = 0;
    endtask

    task automatic model_edge();
        bit ireq;
        bit dreq;
        if (rst) begin
            model_reset();
            return;
        end
        ireq = i_read;
        dreq = d_read | d_write;
        if (own == NONE) begin
            if (dreq && (!ireq || dstreak < SL)) begin
                own     = OWN_D;
                m_wr    = d_write;
                m_addr  = d_address;
                m_wdata = d_wdata;
                dstreak = ireq ? ((dstreak < SL) ? dstreak + 1 : SL) : 0;
                lat     = next_lat;
            end else if (ireq) begin
                own     = OWN_I;
                m_wr    = 1'b0;
                m_addr  = i_address;
                dstreak = 0;
                lat     = next_lat;
            end
        end else if (l2_resp) begin
            own = NONE;
        end
    endtask

    task automatic check_outputs();
        check("l2_read", LW'(l2_read), LW'(own != NONE && !m_wr));
        check("l2_write", LW'(l2_write), LW'(own == OWN_D && m_wr));
        check("l2_address", LW'(l2_address), LW'(m_addr));
        check("l2_wdata", l2_wdata, m_wdata);
        check("i_resp", LW'(i_resp), LW'(own == OWN_I && l2_resp));
        check("d_resp", LW'(d_resp), LW'(own == OWN_D && l2_resp));
        if (own == OWN_I && l2_resp) check("i_rdata", i_rdata, l2_rdata);
        if (own == OWN_D && l2_resp) check("d_rdata", d_rdata, l2_rdata);
    endtask

    // Called at a negedge with inputs already set for this cycle
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Behavioural L2: answers after the latency chosen at grant
    task automatic drive_l2(input bit stray);
        l2_rdata = rand_line();
        if (own != NONE) begin
            l2_resp = (lat == 0);
            if (lat > 0) lat--;
        end else begin
            l2_resp = stray && ($urandom_range(7) == 0);
        end
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        int n = 0;
        while (own != NONE && n < budget) begin
            drive_l2(1'b0);
            tick();
            n++;
        end
        check(tag, LW'(own == NONE), LW'(1));
    endtask

    logic [AW-1:0] grants[$];
    logic [AW-1:0] exp_grants[6];
    bit            prev_busy;
    bit            busy;
    bit            i_done;
    bit            d_done;
    int            n;

    initial begin
        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        l2_resp   = 1'b0;
        l2_rdata  = '0;
        next_lat  = 2;
        model_reset();
        @(negedge clk);
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // I-only read, L2 answers after 5 cycles
        i_read    = 1'b1;
        i_address = 32'h0000_1040;
        next_lat  = 4;
        tick();
        check("t1_grant_i", LW'(own == OWN_I), LW'(1));
        run_to_idle("t1_done", 20);
        i_read = 1'b0;
        tick();

        // D write of a full line
        d_write   = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata   = rand_line();
        next_lat  = 3;
        tick();
        check("t2_grant_d", LW'(own == OWN_D && m_wr), LW'(1));
        run_to_idle("t2_done", 20);
        d_write = 1'b0;
        tick();

        // Both requesting continuously: D, D, I, D, D, I with limit 2
        i_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_read    = 1'b1;
        d_address = 32'h0000_0200;
        prev_busy = 1'b0;
        grants.delete();
        n = 0;
        while (grants.size() < 6 && n < 200) begin
            next_lat = $urandom_range(0, 3);
            drive_l2(1'b0);
            tick();
            busy = l2_read | l2_write;
            if (busy && !prev_busy) grants.push_back(l2_address);
            prev_busy = busy;
            n++;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        check("t3_count", LW'(grants.size()), LW'(6));
        exp_grants = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};
        for (int k = 0; k < 6 && k < grants.size(); k++)
            check($sformatf("t3_grant%0d", k), LW'(grants[k]), LW'(exp_grants[k]));
        run_to_idle("t3_drain", 20);
        tick();

        // D request fields wander while the transaction is in flight
        d_read    = 1'b1;
        d_address = 32'h0000_3000;
        next_lat  = 6;
        tick();
        n = 0;
        while (own != NONE && n < 20) begin
            d_address = $urandom;
            d_wdata   = rand_line();
            drive_l2(1'b0);
            tick();
            n++;
        end
        check("t4_done", LW'(own == NONE), LW'(1));
        d_read = 1'b0;
        tick();

        // I drops its request before the L2 answers
        i_read    = 1'b1;
        i_address = 32'h0000_4040;
        next_lat  = 5;
        tick();
        i_read = 1'b0;
        run_to_idle("t6_done", 20);
        tick();

        // Reset in the middle of an I transaction
        i_read    = 1'b1;
        i_address = 32'h0000_5060;
        next_lat  = 10;
        tick();
        drive_l2(1'b0);
        tick();
        check("t5_busy", LW'(l2_read), LW'(1));
        l2_resp = 1'b1;
        rst     = 1'b1;
        #1;
        check("t5_async_read", LW'(l2_read), LW'(0));
        check("t5_no_resp", LW'(i_resp), LW'(0));
        check("t5_addr_clr", LW'(l2_address), LW'(0));
        model_reset();
        i_read  = 1'b0;
        l2_resp = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        // Random traffic
        i_done = 1'b0;
        d_done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!i_read && own != OWN_I && $urandom_range(3) == 0) begin
                i_read    = 1'b1;
                i_address = $urandom & ~32'h1f;
            end else if (i_read && own == OWN_I && $urandom_range(15) == 0) begin
                i_read = 1'b0;
            end
            if (!(d_read | d_write) && own != OWN_D && $urandom_range(3) == 0) begin
                d_write   = $urandom_range(1);
                d_read    = !d_write;
                d_address = $urandom & ~32'h1f;
                d_wdata   = rand_line();
            end else if ((d_read | d_write) && own == OWN_D &&
                         $urandom_range(15) == 0) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
            if ((d_read | d_write) && $urandom_range(3) == 0) begin
                d_address = $urandom & ~32'h1f;
                d_wdata   = rand_line();
            end
            next_lat = $urandom_range(0, 6);
            drive_l2(1'b1);
            i_done = (own == OWN_I) && l2_resp;
            d_done = (own == OWN_D) && l2_resp;
            tick();
            if (i_done) i_read = 1'b0;
            if (d_done) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        run_to_idle("rand_drain", 20);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
